multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle RV32I datapath. It sits directly upstream of `AluControl`: it sequences each instruction through fetch, decode, execute, memory and writeback states and drives `ALUOp_out`, which feeds `AluControl.ALUOp_in`. It also drives every datapath mux select and write strobe, and stalls on a memory-ready handshake.

## Interface
Parameters:
- `OPW`, default 7: opcode width.
- `STW`, default 4: state/debug encoding width.

Ports:
- `clk`  in  1  system clock, all state updates on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `opcode`  in  7  instr[6:0] from the instruction register; stable from DECODE until the next FETCH.
- `zero`  in  1  ALU zero flag.
- `mem_ready`  in  1  memory completes the current access this cycle.
- `ALUOp_out`  out  2  to `AluControl`: 00 = add, 01 = sub/compare, 10 = decode by funct.
- `ALUSrcA`  out  2  00 = PC, 01 = OldPC, 10 = rs1.
- `ALUSrcB`  out  2  00 = rs2, 01 = imm, 10 = const 4.
- `ResultSrc`  out  2  00 = ALUOut, 01 = mem data, 10 = ALU result.
- `ImmSrc`  out  2  00 = I, 01 = S, 10 = B, 11 = J.
- `AdrSrc`  out  1  0 = PC, 1 = result.
- `IRWrite`, `PCWrite`, `MemWrite`, `RegWrite`  out  1 each  write strobes.
- `retire`  out  1  one-cycle pulse on the last cycle of an instruction.
- `illegal_op`  out  1  one-cycle pulse on an unsupported opcode in DECODE.
- `state_out`  out  4  current state encoding (debug).

## Operation
- The state register is the only storage. All outputs are Moore-decoded from state, gated by `mem_ready` and `zero` where noted.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMREAD 3, MEMWB 4, MEMWRITE 5, EXECUTER 6, EXECUTEI 7, ALUWB 8, BEQ 9, JAL 10. Codes 11–15 are unused and return to FETCH on the next edge.
- Per-state outputs. Any signal not listed is 0.
  - FETCH: AdrSrc=0, IRWrite=mem_ready, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCWrite=mem_ready. Stays in FETCH while mem_ready=0; goes to DECODE when mem_ready=1.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00. Next state by opcode:
    - 0000011 or 0100011 → MEMADR
    - 0110011 → EXECUTER
    - 0010011 → EXECUTEI
    - 1100011 → BEQ
    - 1101111 → JAL
    - any other opcode → FETCH, with illegal_op=1 and retire=1.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00. lw → MEMREAD; sw → MEMWRITE.
  - MEMREAD: AdrSrc=1, ResultSrc=00. Holds until mem_ready, then → MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, retire=1. → FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite=1 for every cycle in the state. retire=mem_ready. Holds until mem_ready, then → FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10. → ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10. → ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, retire=1. → FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, PCWrite=zero, retire=1. → FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCWrite=1. → ALUWB.
- ImmSrc is combinational from opcode:
  - lw and I-type → 00
  - sw → 01
  - beq → 10
  - jal → 11
  - any other opcode → 00.

## Timing
- Reset: rst_n=0 sampled at a rising edge loads FETCH, including when the FSM is mid-instruction.
  - While rst_n=0, IRWrite, PCWrite, MemWrite, RegWrite, retire and illegal_op are all forced to 0.
  - Once rst_n=1, fetch starts on the first edge.
- Cycle counts with mem_ready always 1:
  - R-type and I-type: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq: 3 cycles.
  - jal: 4 cycles.
- Each cycle with mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Strobes are valid for the whole cycle and are sampled by the datapath at the next rising edge.
- ALUOp_out changes only on state changes. AluControl_out therefore settles combinationally within the same cycle.
- `retire` pulses exactly once per instruction, including illegal opcodes.

## Test plan
- Reset mid-instruction: hold rst_n=0 for 2 cycles while in EXECUTER → state_out=0, all strobes 0 during reset. After release, FETCH asserts IRWrite=1 and PCWrite=1 with mem_ready=1.
- R-type: opcode=0110011, mem_ready=1 → state sequence 0,1,6,8,0. ALUOp_out=10 in state 6; RegWrite=1 and retire=1 in state 8 only.
- lw with stall: opcode=0000011, mem_ready=0 for 2 cycles in MEMREAD → sequence 0,1,2,3,3,3,4,0. AdrSrc=1 throughout MEMREAD; RegWrite only in state 4; ImmSrc=00.
- beq: opcode=1100011 → ALUOp_out=01 in BEQ. With zero=1, PCWrite=1; with zero=0, PCWrite=0. In both cases the next state is FETCH and ImmSrc=10.
- Illegal opcode and sw: opcode=1111111 → DECODE→FETCH with illegal_op=1 for one cycle. opcode=0100011 with mem_ready low for 1 cycle in MEMWRITE → MemWrite=1 for 2 cycles and retire=1 in the second.

Source files
------------

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Main sequencing FSM for the multicycle RV32I datapath; Moore-
//            decodes mux selects, write strobes and ALUOp from the state.
// Revision : 1.0  initial release
// ============================================================================
module multicycle_control #(
    parameter int OPW = 7,
    parameter int STW = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [OPW-1:0] opcode,
    input  logic           zero,
    input  logic           mem_ready,
    output logic [1:0]     ALUOp_out,
    output logic [1:0]     ALUSrcA,
    output logic [1:0]     ALUSrcB,
    output logic [1:0]     ResultSrc,
    output logic [1:0]     ImmSrc,
    output logic           AdrSrc,
    output logic           IRWrite,
    output logic           PCWrite,
    output logic           MemWrite,
    output logic           RegWrite,
    output logic           retire,
    output logic           illegal_op,
    output logic [STW-1:0] state_out
);

    localparam logic [OPW-1:0] c_OP_LW   = OPW'(7'b0000011);
    localparam logic [OPW-1:0] c_OP_SW   = OPW'(7'b0100011);
    localparam logic [OPW-1:0] c_OP_R    = OPW'(7'b0110011);
    localparam logic [OPW-1:0] c_OP_I    = OPW'(7'b0010011);
    localparam logic [OPW-1:0] c_OP_BEQ  = OPW'(7'b1100011);
    localparam logic [OPW-1:0] c_OP_JAL  = OPW'(7'b1101111);

    typedef enum logic [STW-1:0] {
        S_FETCH    = STW'(0),
        S_DECODE   = STW'(1),
        S_MEMADR   = STW'(2),
        S_MEMREAD  = STW'(3),
        S_MEMWB    = STW'(4),
        S_MEMWRITE = STW'(5),
        S_EXECUTER = STW'(6),
        S_EXECUTEI = STW'(7),
        S_ALUWB    = STW'(8),
        S_BEQ      = STW'(9),
        S_JAL      = STW'(10)
    } state_t;

    state_t state_q, state_d;

    logic w_irwrite, w_pcwrite, w_memwrite, w_regwrite, w_retire, w_illegal;

    // Next-state logic; unused encodings fall back to FETCH.
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    c_OP_LW, c_OP_SW: state_d = S_MEMADR;
                    c_OP_R:           state_d = S_EXECUTER;
                    c_OP_I:           state_d = S_EXECUTEI;
                    c_OP_BEQ:         state_d = S_BEQ;
                    c_OP_JAL:         state_d = S_JAL;
                    default:          state_d = S_FETCH;
                endcase
            end
            S_MEMADR:   state_d = (opcode == c_OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            default:    state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        ALUOp_out  = 2'b00;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ResultSrc  = 2'b00;
        AdrSrc     = 1'b0;
        w_irwrite  = 1'b0;
        w_pcwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_regwrite = 1'b0;
        w_retire   = 1'b0;
        w_illegal  = 1'b0;
        case (state_q)
            S_FETCH: begin
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                w_irwrite = mem_ready;
                w_pcwrite = mem_ready;
            end
            S_DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                if (state_d == S_FETCH) begin
                    w_illegal = 1'b1;
                    w_retire  = 1'b1;
                end
            end
            S_MEMADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc     = 1'b1;
                w_memwrite = 1'b1;
                w_retire   = mem_ready;
            end
            S_EXECUTER: begin
                ALUSrcA   = 2'b10;
                ALUOp_out = 2'b10;
            end
            S_EXECUTEI: begin
                ALUSrcA   = 2'b10;
                ALUSrcB   = 2'b01;
                ALUOp_out = 2'b10;
            end
            S_ALUWB: begin
                w_regwrite = 1'b1;
                w_retire   = 1'b1;
            end
            S_BEQ: begin
                ALUSrcA   = 2'b10;
                ALUOp_out = 2'b01;
                w_pcwrite = zero;
                w_retire  = 1'b1;
            end
            S_JAL: begin
                ALUSrcA   = 2'b01;
                ALUSrcB   = 2'b10;
                w_pcwrite = 1'b1;
            end
            default: begin
                ALUOp_out = 2'b00;
            end
        endcase
    end

    always_comb begin
        case (opcode)
            c_OP_SW:  ImmSrc = 2'b01;
            c_OP_BEQ: ImmSrc = 2'b10;
            c_OP_JAL: ImmSrc = 2'b11;
            default:  ImmSrc = 2'b00;
        endcase
    end

    // Strobes are held off for the whole time reset is asserted.
    assign IRWrite    = rst_n & w_irwrite;
    assign PCWrite    = rst_n & w_pcwrite;
    assign MemWrite   = rst_n & w_memwrite;
    assign RegWrite   = rst_n & w_regwrite;
    assign retire     = rst_n & w_retire;
    assign illegal_op = rst_n & w_illegal;
    assign state_out  = state_q;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Directed vector bench for multicycle_control.
// Revision : 1.0  initial release
// ============================================================================
module tb_multicycle_control;

    localparam logic [6:0] c_R   = 7'b0110011;
    localparam logic [6:0] c_I   = 7'b0010011;
    localparam logic [6:0] c_LW  = 7'b0000011;
    localparam logic [6:0] c_SW  = 7'b0100011;
    localparam logic [6:0] c_BEQ = 7'b1100011;
    localparam logic [6:0] c_JAL = 7'b1101111;
    localparam logic [6:0] c_ILL = 7'b1111111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [1:0] ALUOp_out, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc;
    logic       AdrSrc, IRWrite, PCWrite, MemWrite, RegWrite, retire, illegal_op;
    logic [3:0] state_out;

    int checks   = 0;
    int failures = 0;

    multicycle_control #(.OPW(7), .STW(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .ALUOp_out(ALUOp_out), .ALUSrcA(ALUSrcA),
        .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
        .AdrSrc(AdrSrc), .IRWrite(IRWrite), .PCWrite(PCWrite),
        .MemWrite(MemWrite), .RegWrite(RegWrite), .retire(retire),
        .illegal_op(illegal_op), .state_out(state_out)
    );

    always #5 clk = ~clk;

    // exp bundle: {ALUOp,SrcA,SrcB,ResultSrc,ImmSrc,AdrSrc,IRW,PCW,MW,RW,ret,ill}
    typedef struct {
        logic        rst_n;
        logic [6:0]  op;
        logic        z;
        logic        mr;
        logic [3:0]  st;
        logic [16:0] exp;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(logic r, logic [6:0] op, logic z, logic mr, logic [3:0] st,
                                logic [1:0] aop, logic [1:0] sa, logic [1:0] sb,
                                logic [1:0] rs, logic [1:0] imm, logic adr, logic irw,
                                logic pcw, logic mw, logic rw, logic ret, logic ill);
        vec_t v;
        v.rst_n = r; v.op = op; v.z = z; v.mr = mr; v.st = st;
        v.exp = {aop, sa, sb, rs, imm, adr, irw, pcw, mw, rw, ret, ill};
        return v;
    endfunction

    function automatic logic [16:0] actual();
        return {ALUOp_out, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, AdrSrc,
                IRWrite, PCWrite, MemWrite, RegWrite, retire, illegal_op};
    endfunction

    task automatic check(string name, logic [16:0] act, logic [16:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%05h expected 0x%05h", name, act, exp);
        end
    endtask

    task automatic check_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Run one instruction from FETCH with mem_ready=1; return cycles to retire.
    task automatic run_instr(input logic [6:0] op, output int cycles, output int retires);
        cycles = 0;
        retires = 0;
        opcode = op; mem_ready = 1'b1; zero = 1'b0;
        for (int i = 0; i < 20; i++) begin
            #1;
            cycles++;
            if (retire) begin
                retires++;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        #1;
        if (state_out != 4'd0) retires++;
    endtask

    initial begin
        int cyc, ret;
        rst_n = 1'b0; opcode = c_R; zero = 1'b0; mem_ready = 1'b1;
        @(negedge clk);

        //        rst op    z  mr st     aop   sa    sb    rs    imm  adr irw pcw mw rw ret ill
        tv.push_back(mk(0, c_R,   0, 1, 4'd0,  2'b00,2'b00,2'b10,2'b10,2'b00,0,0,0,0,0,0,0));
        tv.push_back(mk(1, c_R,   0, 1, 4'd0,  2'b00,2'b00,2'b10,2'b10,2'b00,0,1,1,0,0,0,0));
        tv.push_back(mk(1, c_R,   0, 1, 4'd1,  2'b00,2'b01,2'b01,2'b00,2'b00,0,0,0,0,0,0,0));
        tv.push_back(mk(1, c_R,   0, 1, 4'd6,  2'b10,2'b10,2'b00,2'b00,2'b00,0,0,0,0,0,0,0));
        tv.push_back(mk(1, c_R,   0, 1, 4'd8,  2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0,0,1,1,0));
        tv.push_back(mk(1, c_I,   0, 0, 4'd0,  2'b00,2'b00,2'b10,2'b10,2'b00,0,0,0,0,0,0,0));
        tv.push_back(mk(1, c_I,   0, 1, 4'd0,  2'b00,2'b00,2'b10,2'b10,2'b00,0,1,1,0,0,0,0));
        tv.push_back(mk(1, c_I,   0, 1, 4'd1,  2'b00,2'b01,2'b01,2'b00,2'b00,0,0,0,0,0,0,0));
        tv.push_back(mk(1, c_I,   0, 1, 4'd7,  2'b10,2'b10,2'b01,2'b00,2'b00,0,0,0,0,0,0,0));
        tv.push_back(mk(1, c_I,   0, 1, 4'd8,  2'b00,2'b00,2'b00,2'b00,2'b00,0,0,0,0,1,1,0));
        tv.push_back(mk(1, c_LW,  0, 1, 4'd0,  2'b00,2'b00,2'b10,2'b10,2'b00,0,1,1,0,0,0,0));
        tv.push_back(mk(1, c_LW,  0, 1, 4'd1,  2'b00,2'b01,2'b01,2'b00,2'b00,0,0,0,0,0,0,0));
        tv.push_back(mk(1, c_LW,  0, 1, 4'd2,  2'b00,2'b10,2'b01,2'b00,2'b00,0,0,0,0,0,0,0));
        tv.push_back(mk(1, c_LW,  0, 0, 4'd3,  2'b00,2'b00,2'b00,2'b00,2'b00,1,0,0,0,0,0,0));
        tv.push_back(mk(1, c_LW,  0, 0, 4'd3,  2'b00,2'b00,2'b00,2'b00,2'b00,1,0,0,0,0,0,0));
        tv.push_back(mk(1, c_LW,  0, 1, 4'd3,  2'b00,2'b00,2'b00,2'b00,2'b00,1,0,0,0,0,0,0));
        tv.push_back(mk(1, c_LW,  0, 1, 4'd4,  2'b00,2'b00,2'b00,2'b01,2'b00,0,0,0,0,1,1,0));
        tv.push_back(mk(1, c_SW,  0, 1, 4'd0,  2'b00,2'b00,2'b10,2'b10,2'b01,0,1,1,0,0,0,0));
        tv.push_back(mk(1, c_SW,  0, 1, 4'd1,  2'b00,2'b01,2'b01,2'b00,2'b01,0,0,0,0,0,0,0));
        tv.push_back(mk(1, c_SW,  0, 1, 4'd2,  2'b00,2'b10,2'b01,2'b00,2'b01,0,0,0,0,0,0,0));
        tv.push_back(mk(1, c_SW,  0, 0, 4'd5,  2'b00,2'b00,2'b00,2'b00,2'b01,1,0,0,1,0,0,0));
        tv.push_back(mk(1, c_SW,  0, 1, 4'd5,  2'b00,2'b00,2'b00,2'b00,2'b01,1,0,0,1,0,1,0));
        tv.push_back(mk(1, c_BEQ, 1, 1, 4'd0,  2'b00,2'b00,2'b10,2'b10,2'b10,0,1,1,0,0,0,0));
        tv.push_back(mk(1, c_BEQ, 1, 1, 4'd1,  2'b00,2'b01,2'b01,2'b00,2'b10,0,0,0,0,0,0,0));
        tv.push_back(mk(1, c_BEQ, 1, 1, 4'd9,  2'b01,2'b10,2'b00,2'b00,2'b10,0,0,1,0,0,1,0));
        tv.push_back(mk(1, c_BEQ, 0, 1, 4'd0,  2'b00,2'b00,2'b10,2'b10,2'b10,0,1,1,0,0,0,0));
        tv.push_back(mk(1, c_BEQ, 0, 1, 4'd1,  2'b00,2'b01,2'b01,2'b00,2'b10,0,0,0,0,0,0,0));
        tv.push_back(mk(1, c_BEQ, 0, 1, 4'd9,  2'b01,2'b10,2'b00,2'b00,2'b10,0,0,0,0,0,1,0));
        tv.push_back(mk(1, c_JAL, 0, 1, 4'd0,  2'b00,2'b00,2'b10,2'b10,2'b11,0,1,1,0,0,0,0));
        tv.push_back(mk(1, c_JAL, 0, 1, 4'd1,  2'b00,2'b01,2'b01,2'b00,2'b11,0,0,0,0,0,0,0));
        tv.push_back(mk(1, c_JAL, 0, 1, 4'd10, 2'b00,2'b01,2'b10,2'b00,2'b11,0,0,1,0,0,0,0));
        tv.push_back(mk(1, c_JAL, 0, 1, 4'd8,  2'b00,2'b00,2'b00,2'b00,2'b11,0,0,0,0,1,1,0));
        tv.push_back(mk(1, c_ILL, 0, 1, 4'd0,  2'b00,2'b00,2'b10,2'b10,2'b00,0,1,1,0,0,0,0));
        tv.push_back(mk(1, c_ILL, 0, 1, 4'd1,  2'b00,2'b01,2'b01,2'b00,2'b00,0,0,0,0,0,1,1));
        tv.push_back(mk(1, c_R,   0, 1, 4'd0,  2'b00,2'b00,2'b10,2'b10,2'b00,0,1,1,0,0,0,0));
        tv.push_back(mk(1, c_R,   0, 1, 4'd1,  2'b00,2'b01,2'b01,2'b00,2'b00,0,0,0,0,0,0,0));
        tv.push_back(mk(0, c_R,   0, 1, 4'd6,  2'b10,2'b10,2'b00,2'b00,2'b00,0,0,0,0,0,0,0));
        tv.push_back(mk(0, c_R,   0, 1, 4'd0,  2'b00,2'b00,2'b10,2'b10,2'b00,0,0,0,0,0,0,0));
        tv.push_back(mk(1, c_R,   0, 1, 4'd0,  2'b00,2'b00,2'b10,2'b10,2'b00,0,1,1,0,0,0,0));
        tv.push_back(mk(1, c_R,   0, 1, 4'd1,  2'b00,2'b01,2'b01,2'b00,2'b00,0,0,0,0,0,0,0));

        foreach (tv[i]) begin
            rst_n = tv[i].rst_n; opcode = tv[i].op; zero = tv[i].z; mem_ready = tv[i].mr;
            #1;
            check_int($sformatf("vec%0d_state", i), int'(state_out), int'(tv[i].st));
            check($sformatf("vec%0d_outputs", i), actual(), tv[i].exp);
            @(negedge clk);
        end

        // Cycle-count sequences from a clean FETCH with mem_ready held high.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        run_instr(c_R,   cyc, ret); check_int("rtype_cycles", cyc, 4); check_int("rtype_retire", ret, 1);
        run_instr(c_I,   cyc, ret); check_int("itype_cycles", cyc, 4); check_int("itype_retire", ret, 1);
        run_instr(c_LW,  cyc, ret); check_int("lw_cycles",    cyc, 5); check_int("lw_retire",    ret, 1);
        run_instr(c_SW,  cyc, ret); check_int("sw_cycles",    cyc, 4); check_int("sw_retire",    ret, 1);
        run_instr(c_BEQ, cyc, ret); check_int("beq_cycles",   cyc, 3); check_int("beq_retire",   ret, 1);
        run_instr(c_JAL, cyc, ret); check_int("jal_cycles",   cyc, 4); check_int("jal_retire",   ret, 1);
        run_instr(c_ILL, cyc, ret); check_int("ill_cycles",   cyc, 2); check_int("ill_retire",   ret, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
